// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP_I = 2'd1,
        RESP_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_t;

    localparam logic [31:0] IROM_BASE_DEFAULT = 32'hBFC00000;
    localparam int          IROM_SIZE_DEFAULT = 4096;
    localparam logic [31:0] NOP_INSN          = 32'h00000013;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin selector: on contention the requester that did not own
// the last grant wins. Grant bit 0 is fetch, bit 1 is data.
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic       fetch_req,
    input  logic       data_req,
    input  owner_t     last_owner,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (fetch_req && data_req) begin
            gnt = (last_owner == OWNER_D) ? 2'b01 : 2'b10;
        end else if (fetch_req) begin
            gnt = 2'b01;
        end else if (data_req) begin
            gnt = 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between a fetch and a data requester with a
// combinational grant and a fixed one-cycle response.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int          ADDRESS_WIDTH = 32,
    parameter int          DATA_WIDTH    = 32,
    parameter logic [31:0] IROM_BASE     = IROM_BASE_DEFAULT,
    parameter int          IROM_SIZE     = IROM_SIZE_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_req,
    input  logic [ADDRESS_WIDTH-1:0] i_addr,
    output logic                     i_gnt,
    output logic                     i_rvalid,
    output logic [DATA_WIDTH-1:0]    i_rdata,
    output logic                     i_err,
    input  logic                     d_req,
    input  logic                     d_we,
    input  logic [3:0]               d_be,
    input  logic [ADDRESS_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0]    d_wdata,
    output logic                     d_gnt,
    output logic                     d_rvalid,
    output logic [DATA_WIDTH-1:0]    d_rdata,
    output logic                     m_req,
    output logic                     m_we,
    output logic [3:0]               m_be,
    output logic [ADDRESS_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0]    m_wdata,
    input  logic [DATA_WIDTH-1:0]    m_rdata
);

    localparam logic [ADDRESS_WIDTH-1:0] IROM_LO = ADDRESS_WIDTH'(IROM_BASE);
    localparam logic [ADDRESS_WIDTH-1:0] IROM_HI =
        ADDRESS_WIDTH'(IROM_BASE + 32'(IROM_SIZE) - 32'd4);

    arb_state_t state;
    arb_state_t state_next;
    owner_t     last_owner;
    owner_t     last_owner_next;
    logic       armed;
    logic       err_pending;
    logic       err_next;
    logic       fetch_ok;
    logic [1:0] gnt;

    // armed stays low through reset and the first cycle after it, masking requests.
    rr_arb2 u_rr_arb2 (
        .fetch_req  (i_req & armed),
        .data_req   (d_req & armed),
        .last_owner (last_owner),
        .gnt        (gnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_owner  <= OWNER_D;
            armed       <= 1'b0;
            err_pending <= 1'b0;
        end else begin
            state       <= state_next;
            last_owner  <= last_owner_next;
            armed       <= 1'b1;
            err_pending <= err_next;
        end
    end

    always_comb begin
        state_next      = IDLE;
        last_owner_next = last_owner;
        err_next        = 1'b0;
        if (gnt[0]) begin
            state_next      = RESP_I;
            last_owner_next = OWNER_I;
            err_next        = ~fetch_ok;
        end else if (gnt[1]) begin
            state_next      = RESP_D;
            last_owner_next = OWNER_D;
        end
    end

    // A rejected fetch is still granted but never reaches memory.
    always_comb begin
        fetch_ok = (i_addr >= IROM_LO) && (i_addr <= IROM_HI) && (i_addr[1:0] == 2'b00);
        i_gnt    = gnt[0];
        d_gnt    = gnt[1];
        m_req    = gnt[1] | (gnt[0] & fetch_ok);
        m_we     = gnt[1] & d_we;
        m_be     = gnt[1] ? d_be : 4'hF;
        m_addr   = gnt[1] ? d_addr : i_addr;
        m_wdata  = gnt[1] ? d_wdata : '0;
        i_rvalid = (state == RESP_I);
        i_err    = (state == RESP_I) & err_pending;
        i_rdata  = err_pending ? DATA_WIDTH'(NOP_INSN) : m_rdata;
        d_rvalid = (state == RESP_D);
        d_rdata  = m_rdata;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- ADDRESS_WIDTH, 32, address bits.
- DATA_WIDTH, 32, word bits.
- IROM_BASE, 32'hBFC00000, instruction window base.
- IROM_SIZE, 4096, instruction window size in bytes.
REQ-002 There SHALL be one clock, clk; reset rst SHALL be asynchronous and active-high.
REQ-003 Ports SHALL be, one per line as name, direction, width, meaning:
- clk  in  1  clock.
- rst  in  1  async active-high reset.
- i_req  in  1  fetch request.
- i_addr  in  ADDRESS_WIDTH  fetch byte address.
- i_gnt  out  1  fetch accepted this cycle.
- i_rvalid  out  1  fetch response valid.
- i_rdata  out  DATA_WIDTH  fetched word.
- i_err  out  1  fetch response is an error.
- d_req  in  1  data request.
- d_we  in  1  data write.
- d_be  in  4  byte enables.
- d_addr  in  ADDRESS_WIDTH  data byte address.
- d_wdata  in  DATA_WIDTH  write data.
- d_gnt  out  1  data accepted.
- d_rvalid  out  1  data response valid.
- d_rdata  out  DATA_WIDTH  read data.
- m_req  out  1  memory access.
- m_we  out  1  memory write.
- m_be  out  4  memory byte enables.
- m_addr  out  ADDRESS_WIDTH  memory address.
- m_wdata  out  DATA_WIDTH  memory write data.
- m_rdata  in  DATA_WIDTH  memory read data, valid one cycle after m_req.

Function
REQ-004 The block SHALL share one single-port memory between fetch and data requesters, granting at most one per cycle.
REQ-005 Grant SHALL be combinational in the request cycle; i_gnt and d_gnt SHALL never both be high.
REQ-006 Arbitration SHALL be round-robin: a 1-bit last-owner register selects the other requester when both request, otherwise the sole requester wins.
REQ-007 The last-owner register SHALL update only on a grant.
REQ-008 On grant, m_req SHALL be 1 and m_addr/m_we/m_be/m_wdata SHALL mirror the winner's inputs.
REQ-009 A fetch grant SHALL drive m_we=0 and m_be=4'hF.
REQ-010 Response latency SHALL be exactly one cycle: rvalid to the owner of the previous-cycle grant, with rdata = m_rdata.
REQ-011 A data write SHALL also return d_rvalid one cycle later, with d_rdata don't-care.
REQ-012 Back-to-back grants SHALL be allowed every cycle, giving a throughput of one access per cycle.
REQ-013 A fetch with i_addr outside [IROM_BASE, IROM_BASE+IROM_SIZE-4], or with i_addr[1:0]!=0, SHALL be granted without asserting m_req.
REQ-014 That fetch SHALL get i_rvalid=1, i_err=1 and i_rdata=32'h00000013 (NOP) next cycle; i_err SHALL otherwise be 0.
REQ-015 Internal sequencing SHALL use states IDLE (no outstanding access), RESP_I and RESP_D (one outstanding).
REQ-016 From any state, a new grant SHALL select RESP_I or RESP_D; no grant SHALL return to IDLE.
REQ-017 Fetch and data requests SHALL be ignored for one cycle after reset deasserts.

Reset
REQ-018 Asserting rst SHALL immediately force:
- state=IDLE, last-owner=data (fetch wins the first contention);
- all gnt, rvalid, i_err and m_req outputs=0.
REQ-019 Reset mid-transaction SHALL drop the outstanding response, with no rvalid after reset.

Structure
REQ-020 A shared package SHALL hold:
- the arbiter state enum;
- the owner enum;
- the IROM_BASE/IROM_SIZE defaults;
- the NOP constant.
REQ-021 The round-robin selector SHALL be a sub-module rr_arb2 (two requests, last-owner in, one-hot grant out).
REQ-022 All sequential logic SHALL sit in one always_ff with async reset; all output logic SHALL be always_comb.

Verification
REQ-023 The bench SHALL cover these scenarios, each as stimulus -> required response:
- Reset, then i_req alone at 0xBFC00000 -> i_gnt same cycle, m_addr=0xBFC00000, i_rvalid next cycle with memory word.
- Both request for 4 cycles -> grants alternate I,D,I,D; each rvalid goes to the correct port one cycle later.
- d_req write 0x12345678 to 0x00000100 with be=4'b0011 -> m_we=1, m_be=4'b0011; d_rvalid next cycle; i_rvalid stays 0.
- i_req at 0xBFC01000 and at 0xBFC00002 -> i_gnt, m_req=0, next cycle i_rvalid=1, i_err=1, i_rdata=0x00000013.
- rst asserted the cycle after a data read grant -> no d_rvalid; state IDLE; after release, first contention granted to fetch.
- Continuous fetch stream over 16 words -> one i_rvalid per cycle, addresses strictly increasing, no bubbles.
